// File: rtl/noise_ctrl_pkg.sv
// Shared types and constants for the noise_ctrl block: FSM states, command
// encodings, channel count and the activity-monitor window length.
package noise_ctrl_pkg;

    localparam int NCH       = 16;
    localparam int MON_WIN   = 4096;
    localparam int MON_CNT_W = $clog2(MON_WIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DN
    } state_e;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_SEED  = 2'b01,
        OP_RUN   = 2'b10,
        OP_BURST = 2'b11
    } cmd_op_e;

    function automatic logic [NCH-1:0] rotl16(input logic [NCH-1:0] v, input logic [3:0] r);
        logic [2*NCH-1:0] t;
        t = {v, v} << r;
        return t[2*NCH-1:NCH];
    endfunction

    function automatic logic [4:0] popcount16(input logic [NCH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/noise_ctrl_mon.sv
// Activity monitor: sums popcount(dac_in & dac_en) over fixed windows and
// publishes each window total with a one-cycle mon_valid pulse.
module noise_ctrl_mon
    import noise_ctrl_pkg::*;
(
    input  logic        sclk,
    input  logic        rst,
    input  logic [15:0] dac_in,
    input  logic [15:0] dac_en,
    output logic [23:0] mon_sum,
    output logic        mon_valid
);

    localparam logic [MON_CNT_W-1:0] WIN_LAST = MON_CNT_W'(MON_WIN - 1);

    logic [MON_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [23:0]          acc_q, acc_d;
    logic [23:0]          mon_sum_q, mon_sum_d;
    logic                 mon_valid_q, mon_valid_d;
    logic [23:0]          acc_next;

    always_comb begin
        acc_next    = acc_q + 24'(popcount16(dac_in & dac_en));
        win_cnt_d   = win_cnt_q + MON_CNT_W'(1);
        acc_d       = acc_next;
        mon_sum_d   = mon_sum_q;
        mon_valid_d = 1'b0;
        // Last sample of the window goes straight into the published total.
        if (win_cnt_q == WIN_LAST) begin
            win_cnt_d   = '0;
            acc_d       = '0;
            mon_sum_d   = acc_next;
            mon_valid_d = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            mon_sum_q   <= '0;
            mon_valid_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            mon_sum_q   <= mon_sum_d;
            mon_valid_q <= mon_valid_d;
        end
    end

    assign mon_sum   = mon_sum_q;
    assign mon_valid = mon_valid_q;

endmodule

// File: rtl/noise_ctrl.sv
// noise_ctrl: seeds a 16-channel LFSR noise bank and ramps its DAC amplitude mask.
// Defining NOISE_CTRL_MON_EN adds the dac_in/mon_sum/mon_valid activity monitor.
module noise_ctrl
    import noise_ctrl_pkg::*;
#(
    parameter int RAMP_DIV = 256,
    parameter int SEED_ROT = 1
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_arg,
    output logic        lfsr_load,
    output logic [3:0]  lfsr_sel,
    output logic [15:0] lfsr_seed,
    output logic [15:0] dac_en,
    output logic        busy,
    output logic        done
`ifdef NOISE_CTRL_MON_EN
    ,
    input  logic [15:0] dac_in,
    output logic [23:0] mon_sum,
    output logic        mon_valid
`endif
);

    localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);
    localparam logic [3:0]  ROT_STEP  = 4'(SEED_ROT % NCH);

    state_e      state_q, state_d;
    logic [15:0] dac_en_q, dac_en_d;
    logic [15:0] ramp_cnt_q, ramp_cnt_d;
    logic [23:0] burst_cnt_q, burst_cnt_d;
    logic        burst_q, burst_d;
    logic [15:0] seed_q, seed_d;
    logic        lfsr_load_q, lfsr_load_d;
    logic [3:0]  lfsr_sel_q, lfsr_sel_d;
    logic [15:0] lfsr_seed_q, lfsr_seed_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        ramp_tick;

    always_comb begin
        state_d     = state_q;
        dac_en_d    = dac_en_q;
        ramp_cnt_d  = ramp_cnt_q;
        burst_cnt_d = burst_cnt_q;
        burst_d     = burst_q;
        seed_d      = seed_q;
        lfsr_load_d = 1'b0;
        lfsr_sel_d  = '0;
        lfsr_seed_d = '0;
        done_d      = 1'b0;
        accept      = cmd_valid && cmd_ready_q;
        ramp_tick   = (ramp_cnt_q == RAMP_LAST);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SEED: begin
                            state_d     = ST_SEED;
                            seed_d      = (cmd_arg[15:0] == 16'h0000) ? 16'h0001 : cmd_arg[15:0];
                            lfsr_load_d = 1'b1;
                            lfsr_seed_d = seed_d;
                        end
                        OP_RUN, OP_BURST: begin
                            state_d     = ST_RAMP_UP;
                            dac_en_d    = '0;
                            ramp_cnt_d  = '0;
                            burst_d     = (cmd_op == OP_BURST);
                            burst_cnt_d = cmd_arg;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SEED: begin
                if (lfsr_sel_q == 4'd15) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    lfsr_load_d = 1'b1;
                    lfsr_sel_d  = lfsr_sel_q + 4'd1;
                    lfsr_seed_d = rotl16(seed_q, lfsr_sel_d * ROT_STEP);
                end
            end
            ST_RAMP_UP: begin
                if (accept && cmd_op == OP_STOP) begin
                    state_d    = ST_RAMP_DN;
                    ramp_cnt_d = '0;
                end else if (ramp_tick) begin
                    ramp_cnt_d = '0;
                    dac_en_d   = {dac_en_q[14:0], 1'b1};
                    // A zero-length burst skips RUN entirely.
                    if (dac_en_d == 16'hFFFF) begin
                        state_d = (burst_q && burst_cnt_q == '0) ? ST_RAMP_DN : ST_RUN;
                    end
                end else begin
                    ramp_cnt_d = ramp_cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (accept && cmd_op == OP_STOP) begin
                    state_d     = ST_RAMP_DN;
                    ramp_cnt_d  = '0;
                    burst_cnt_d = '0;
                end else if (burst_q) begin
                    if (burst_cnt_q <= 24'd1) begin
                        state_d     = ST_RAMP_DN;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q - 24'd1;
                    end
                end
            end
            ST_RAMP_DN: begin
                if (ramp_tick) begin
                    ramp_cnt_d = '0;
                    dac_en_d   = {1'b0, dac_en_q[15:1]};
                    if (dac_en_d == 16'h0000) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ramp_cnt_d = ramp_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RAMP_UP) || (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dac_en_q    <= '0;
            ramp_cnt_q  <= '0;
            burst_cnt_q <= '0;
            burst_q     <= 1'b0;
            seed_q      <= '0;
            lfsr_load_q <= 1'b0;
            lfsr_sel_q  <= '0;
            lfsr_seed_q <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dac_en_q    <= dac_en_d;
            ramp_cnt_q  <= ramp_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            burst_q     <= burst_d;
            seed_q      <= seed_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_sel_q  <= lfsr_sel_d;
            lfsr_seed_q <= lfsr_seed_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign lfsr_load = lfsr_load_q;
    assign lfsr_sel  = lfsr_sel_q;
    assign lfsr_seed = lfsr_seed_q;
    assign dac_en    = dac_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef NOISE_CTRL_MON_EN
    noise_ctrl_mon u_mon (
        .sclk      (sclk),
        .rst       (rst),
        .dac_in    (dac_in),
        .dac_en    (dac_en_q),
        .mon_sum   (mon_sum),
        .mon_valid (mon_valid)
    );
`endif

endmodule

// File: tb/tb_noise_ctrl.sv
// Randomized self-checking bench for noise_ctrl; expected masks, seeds and
// handshakes are derived from cycle offsets after each accepted command.
module tb_noise_ctrl;

    localparam int RD  = 4;
    localparam int ROT = 1;

    logic        sclk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_arg;
    logic        lfsr_load;
    logic [3:0]  lfsr_sel;
    logic [15:0] lfsr_seed;
    logic [15:0] dac_en;
    logic        busy;
    logic        done;
`ifdef NOISE_CTRL_MON_EN
    logic [15:0] dac_in;
    logic [23:0] mon_sum;
    logic        mon_valid;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 sclk = ~sclk;

    noise_ctrl #(.RAMP_DIV(RD), .SEED_ROT(ROT)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .lfsr_load (lfsr_load),
        .lfsr_sel  (lfsr_sel),
        .lfsr_seed (lfsr_seed),
        .dac_en    (dac_en),
        .busy      (busy),
        .done      (done)
`ifdef NOISE_CTRL_MON_EN
        ,
        .dac_in    (dac_in),
        .mon_sum   (mon_sum),
        .mon_valid (mon_valid)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [23:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = '0;
    endtask

    // Amplitude mask after t cycles of ramping up from zero.
    function automatic int up_mask(input int t);
        int steps;
        steps = t / RD;
        return (steps >= 16) ? 32'hFFFF : ((1 << steps) - 1);
    endfunction

    function automatic int model_seed(input int s, input int k);
        int v, r;
        v = (s == 0) ? 1 : s;
        r = (k * ROT) % 16;
        return ((v << r) | (v >> (16 - r))) & 32'hFFFF;
    endfunction

    task automatic do_seed(input int s);
        send(2'b01, 24'(s));
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("seed_k%0d", k),
                     32'({lfsr_load, lfsr_sel, lfsr_seed, cmd_ready, busy, done}),
                     32'({1'b1, 4'(k), 16'(model_seed(s, k)), 3'b010}));
            if (s == 'hA5A5 && k == 1) check_eq("seed_a5a5_k1", 32'(lfsr_seed), 32'h4B4B);
            if (s == 0 && k == 0)      check_eq("seed_zero_k0", 32'(lfsr_seed), 32'h0001);
            if (s == 0 && k == 15)     check_eq("seed_zero_k15", 32'(lfsr_seed), 32'h8000);
            tick();
        end
        check_eq("seed_done", 32'({lfsr_load, lfsr_sel, lfsr_seed, cmd_ready, busy, done}),
                 32'({1'b0, 4'd0, 16'd0, 3'b101}));
        tick();
        check_eq("seed_after", 32'({cmd_ready, busy, done}), 32'b100);
    endtask

    task automatic do_burst(input int len);
        send(2'b11, 24'(len));
        for (int t = 0; t <= 128 + len; t++) begin
            int   em;
            logic er, ed;
            if (t < 64) begin
                em = up_mask(t);
                er = 1'b1;
            end else if (t < 64 + len) begin
                em = 32'hFFFF;
                er = 1'b1;
            end else begin
                em = 32'hFFFF >> ((t - 64 - len) / RD);
                er = 1'b0;
            end
            ed = (t == 128 + len);
            if (ed) er = 1'b1;
            check_eq($sformatf("burst%0d_t%0d", len, t), 32'({dac_en, cmd_ready, busy, done}),
                     32'({16'(em), er, !ed, ed}));
            tick();
        end
        check_eq("burst_idle", 32'({dac_en, cmd_ready, busy, done}), 32'b100);
    endtask

    // RUN, a discarded non-STOP command at cycle d, then STOP accepted at cycle s.
    task automatic do_run_stop(input int s, input int d, input logic [1:0] junk_op);
        int m, w, fin;
        m   = up_mask(s - 1);
        w   = ((s - 1) / RD >= 16) ? 16 : (s - 1) / RD;
        fin = s + w * RD;
        send(2'b10, '0);
        for (int t = 0; t <= fin; t++) begin
            int   em;
            logic er, ed;
            if (t < s) begin
                em = up_mask(t);
                er = 1'b1;
            end else begin
                em = m >> ((t - s) / RD);
                er = 1'b0;
            end
            ed = (t == fin);
            if (ed) er = 1'b1;
            check_eq($sformatf("runstop%0d_t%0d", s, t), 32'({dac_en, cmd_ready, busy, done}),
                     32'({16'(em), er, !ed, ed}));
            if (m == 'hFF && t == s + RD) check_eq("stop_ff_next", 32'(dac_en), 32'h007F);
            if (t + 1 == d) begin
                cmd_valid = 1'b1;
                cmd_op    = junk_op;
                cmd_arg   = 24'($urandom);
            end else if (t + 1 == s) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                cmd_arg   = '0;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("runstop_idle", 32'({dac_en, cmd_ready, busy, done}), 32'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = '0;
`ifdef NOISE_CTRL_MON_EN
        dac_in    = '0;
`endif
        repeat (3) @(posedge sclk);
        #1;
        check_eq("rst_state", 32'({dac_en, lfsr_load, lfsr_sel, lfsr_seed, cmd_ready, busy, done}), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rdy_low_after_rst", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("rdy_high", 32'({cmd_ready, busy, done}), 32'b100);

        do_seed('hA5A5);
        do_seed(0);
        repeat (3) do_seed(int'($urandom_range(0, 65535)));

        send(2'b00, '0);
        check_eq("stop_idle0", 32'({dac_en, cmd_ready, busy, done}), 32'b100);
        tick();
        check_eq("stop_idle1", 32'({dac_en, cmd_ready, busy, done}), 32'b100);

        do_burst(10);
        do_burst(0);
        repeat (2) do_burst(int'($urandom_range(1, 30)));

        s = 33 + int'($urandom_range(0, 3));
        do_run_stop(s, int'($urandom_range(1, s - 1)), 2'($urandom_range(1, 3)));
        repeat (3) begin
            s = int'($urandom_range(5, 100));
            do_run_stop(s, int'($urandom_range(1, s - 1)), 2'($urandom_range(1, 3)));
        end

`ifdef NOISE_CTRL_MON_EN
        begin
            int pulses;
            pulses = 0;
            dac_in = 16'hFFFF;
            send(2'b10, '0);
            repeat (70) tick();
            for (int c = 0; c < 10000 && pulses < 2; c++) begin
                tick();
                if (mon_valid) begin
                    pulses++;
                    if (pulses == 2) check_eq("mon_sum", 32'(mon_sum), 32'd65536);
                end
            end
            check_eq("mon_pulses", 32'(pulses), 32'd2);
            send(2'b00, '0);
            repeat (70) tick();
            check_eq("mon_stop_idle", 32'({dac_en, busy}), 32'd0);
            dac_in = '0;
        end
`endif

        send(2'b10, '0);
        repeat (20) tick();
        check_eq("pre_rst_mask", 32'(dac_en), 32'h001F);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async", 32'({dac_en, busy, cmd_ready, done, lfsr_load}), 32'd0);
        tick();
        rst = 1'b0;
        check_eq("rst_rdy_low", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("rst_rdy_high", 32'({cmd_ready, busy}), 32'b10);
        do_seed(int'($urandom_range(0, 65535)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
